// File: rtl/cpu_pkg.sv
// Shared definitions for the general-bus arbiter.
// Contents: arbiter state and bus-owner encodings, default bus widths, and a
// helper that sizes down-counters and saturating counters.
package cpu_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_X    = 2'd2
  } owner_e;

  // Bits needed to hold values 0..max_val. Never returns less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(max_val + 32'sd1);
    end
  endfunction

endpackage

// File: rtl/gbus_arbiter_if.sv
// Bundle of the signals around the general-bus arbiter.
// Fetch side   : f_req, f_addr, f_ack.
// Execute side : x_req, x_we, x_addr, x_wdata, x_ack, pause_read.
// Shared read  : rd_data.
// Bus side     : bus_addr, bus_wdata, bus_we, bus_rd, bus_rdata.
// Modports: slave is the arbiter, master is the pipeline/interconnect side.
interface gbus_arbiter_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic              x_req;
  logic              x_we;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata;
  logic              x_ack;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic              bus_rd;
  logic [DATA_W-1:0] bus_rdata;
  logic              pause_read;

  modport slave (
    input  f_req, f_addr, x_req, x_we, x_addr, x_wdata, bus_rdata,
    output f_ack, x_ack, rd_data, bus_addr, bus_wdata, bus_we, bus_rd,
           pause_read
  );

  modport master (
    output f_req, f_addr, x_req, x_we, x_addr, x_wdata, bus_rdata,
    input  f_ack, x_ack, rd_data, bus_addr, bus_wdata, bus_we, bus_rd,
           pause_read
  );
endinterface

// File: rtl/gbus_starve_counter.sv
// Counts consecutive execute grants that were won while fetch was waiting.
// Ports: clk, reset (async, active-low), grant_x / grant_f (one-cycle grant
// strobes from the arbiter), f_req (fetch waiting), at_max (counter has
// reached STARVE_MAX, so fetch must win the next contested arbitration).
module gbus_starve_counter
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_x,
  input  logic grant_f,
  input  logic f_req,
  output logic at_max
);
  localparam int CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: only a grant changes it; contested X grants saturate upward.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_x && f_req) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = CNT_MAX;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (grant_x || grant_f) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_MAX);
endmodule

// File: rtl/gbus_arbiter.sv
// Arbiter sharing the general bus between fetch (read-only) and execute
// (load/store). Execute has priority; after STARVE_MAX consecutive contested
// execute grants, fetch is forced to win. A granted transaction drives the
// bus for MEM_LAT cycles, then the owner's ack pulses for one cycle.
// Ports: clk, reset (async, active-low), gbus (slave modport carrying the
// requester handshakes, captured read data, bus strobes and pause_read).
// Every output is a flop.
module gbus_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input logic           clk,
  input logic           reset,
  gbus_arbiter_if.slave gbus
);
  localparam int LAT_W = cnt_width(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              f_ack_q, f_ack_d;
  logic              x_ack_q, x_ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_we_q, bus_we_d;
  logic              bus_rd_q, bus_rd_d;
  logic              pause_read_q, pause_read_d;
  logic              grant_x_s, grant_f_s, at_max_s;

  gbus_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .grant_x(grant_x_s),
    .grant_f(grant_f_s),
    .f_req  (gbus.f_req),
    .at_max (at_max_s)
  );

  // Arbitration, bus sequencing and ack generation.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    f_ack_d      = 1'b0;
    x_ack_d      = 1'b0;
    rd_data_d    = rd_data_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_we_d     = bus_we_q;
    bus_rd_d     = bus_rd_q;
    pause_read_d = pause_read_q;
    grant_x_s    = 1'b0;
    grant_f_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A starved fetch only overrides execute while it is still asking.
        if (gbus.x_req && !(gbus.f_req && at_max_s)) begin
          grant_x_s    = 1'b1;
          state_d      = ST_BUSY;
          owner_d      = OWN_X;
          lat_cnt_d    = LAT_INIT;
          bus_addr_d   = gbus.x_addr;
          bus_wdata_d  = gbus.x_wdata;
          bus_we_d     = gbus.x_we;
          bus_rd_d     = !gbus.x_we;
          pause_read_d = 1'b1;
        end else if (gbus.f_req) begin
          grant_f_s    = 1'b1;
          state_d      = ST_BUSY;
          owner_d      = OWN_F;
          lat_cnt_d    = LAT_INIT;
          bus_addr_d   = gbus.f_addr;
          bus_we_d     = 1'b0;
          bus_rd_d     = 1'b1;
          pause_read_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (lat_cnt_q == '0) begin
          if (bus_rd_q) begin
            rd_data_d = gbus.bus_rdata;
          end else begin
            rd_data_d = rd_data_q;
          end
          f_ack_d      = (owner_q == OWN_F);
          x_ack_d      = (owner_q == OWN_X);
          bus_we_d     = 1'b0;
          bus_rd_d     = 1'b0;
          pause_read_d = 1'b0;
          owner_d      = OWN_NONE;
          state_d      = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_ONE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        owner_d      = OWN_NONE;
        bus_we_d     = 1'b0;
        bus_rd_d     = 1'b0;
        pause_read_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      lat_cnt_q    <= '0;
      f_ack_q      <= 1'b0;
      x_ack_q      <= 1'b0;
      rd_data_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_we_q     <= 1'b0;
      bus_rd_q     <= 1'b0;
      pause_read_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      f_ack_q      <= f_ack_d;
      x_ack_q      <= x_ack_d;
      rd_data_q    <= rd_data_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_we_q     <= bus_we_d;
      bus_rd_q     <= bus_rd_d;
      pause_read_q <= pause_read_d;
    end
  end

  assign gbus.f_ack      = f_ack_q;
  assign gbus.x_ack      = x_ack_q;
  assign gbus.rd_data    = rd_data_q;
  assign gbus.bus_addr   = bus_addr_q;
  assign gbus.bus_wdata  = bus_wdata_q;
  assign gbus.bus_we     = bus_we_q;
  assign gbus.bus_rd     = bus_rd_q;
  assign gbus.pause_read = pause_read_q;
endmodule

// File: tb/tb_gbus_arbiter.sv
// Directed bench for gbus_arbiter (MEM_LAT=2, STARVE_MAX=3).
// Inputs change 1 time unit after a rising edge; outputs are compared at
// the same point, so each vector's expectation is the register state after
// the edge that sampled its inputs.
module tb_gbus_arbiter;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  gbus_arbiter_if #(.DATA_W(14), .ADDR_W(12)) gif ();

  gbus_arbiter #(
    .DATA_W    (14),
    .ADDR_W    (12),
    .MEM_LAT   (2),
    .STARVE_MAX(3)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .gbus (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {f_ack, x_ack, rd_data, bus_addr, bus_wdata, bus_we, bus_rd, pause_read}.
  typedef struct {
    logic        f_req;
    logic [11:0] f_addr;
    logic        x_req;
    logic        x_we;
    logic [11:0] x_addr;
    logic [13:0] x_wdata;
    logic [13:0] bus_rdata;
    logic [44:0] exp_out;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [44:0] outs();
    return {gif.f_ack, gif.x_ack, gif.rd_data, gif.bus_addr, gif.bus_wdata,
            gif.bus_we, gif.bus_rd, gif.pause_read};
  endfunction

  function automatic vec_t mk(input logic fr, input logic [11:0] fa,
                              input logic xr, input logic xw,
                              input logic [11:0] xa, input logic [13:0] xd,
                              input logic [13:0] rdt,
                              input logic efa, input logic exa,
                              input logic [13:0] erd, input logic [11:0] eaddr,
                              input logic [13:0] ewd, input logic ewe,
                              input logic erds, input logic ep);
    vec_t v;
    v.f_req     = fr;
    v.f_addr    = fa;
    v.x_req     = xr;
    v.x_we      = xw;
    v.x_addr    = xa;
    v.x_wdata   = xd;
    v.bus_rdata = rdt;
    v.exp_out   = {efa, exa, erd, eaddr, ewd, ewe, erds, ep};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    gif.f_req     = v.f_req;
    gif.f_addr    = v.f_addr;
    gif.x_req     = v.x_req;
    gif.x_we      = v.x_we;
    gif.x_addr    = v.x_addr;
    gif.x_wdata   = v.x_wdata;
    gif.bus_rdata = v.bus_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   n_acks;
    int   viol;
    int   last_f;
    int   f_gap;
    int   quiet_bad;
    logic [7:0] got_f;

    checks   = 0;
    failures = 0;

    //           f_req f_addr  x_req we x_addr  x_wdata   rdata   | f_ack x_ack rd_data  addr    wdata    we rd pause
    // fetch read 0x010, data 0x1ABC
    vecs[0]  = mk(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 14'h0000, 14'h1ABC, 1'b0, 1'b0, 14'h0000, 12'h010, 14'h0000, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 14'h0000, 14'h1ABC, 1'b0, 1'b0, 14'h0000, 12'h010, 14'h0000, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 14'h0000, 14'h1ABC, 1'b1, 1'b0, 14'h1ABC, 12'h010, 14'h0000, 1'b0, 1'b0, 1'b0);
    // execute write in the fetch ack cycle; bus_rdata must not reach rd_data
    vecs[3]  = mk(1'b0, 12'h010, 1'b1, 1'b1, 12'h200, 14'h0F0F, 14'h2222, 1'b0, 1'b0, 14'h1ABC, 12'h200, 14'h0F0F, 1'b1, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 12'h010, 1'b1, 1'b1, 12'h200, 14'h0F0F, 14'h2222, 1'b0, 1'b0, 14'h1ABC, 12'h200, 14'h0F0F, 1'b1, 1'b0, 1'b1);
    vecs[5]  = mk(1'b0, 12'h010, 1'b1, 1'b1, 12'h200, 14'h0F0F, 14'h2222, 1'b0, 1'b1, 14'h1ABC, 12'h200, 14'h0F0F, 1'b0, 1'b0, 1'b0);
    // execute read requested in the x ack cycle: bus_rd one cycle after ack
    vecs[6]  = mk(1'b0, 12'h010, 1'b1, 1'b0, 12'h123, 14'h3333, 14'h0555, 1'b0, 1'b0, 14'h1ABC, 12'h123, 14'h3333, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mk(1'b0, 12'h010, 1'b1, 1'b0, 12'h123, 14'h3333, 14'h0555, 1'b0, 1'b0, 14'h1ABC, 12'h123, 14'h3333, 1'b0, 1'b1, 1'b1);
    vecs[8]  = mk(1'b0, 12'h010, 1'b1, 1'b0, 12'h123, 14'h3333, 14'h0555, 1'b0, 1'b1, 14'h0555, 12'h123, 14'h3333, 1'b0, 1'b0, 1'b0);
    // idle: addr/wdata hold
    vecs[9]  = mk(1'b0, 12'h010, 1'b0, 1'b0, 12'h123, 14'h3333, 14'h0555, 1'b0, 1'b0, 14'h0555, 12'h123, 14'h3333, 1'b0, 1'b0, 1'b0);
    // fetch with f_addr changed mid-transaction: bus_addr stays 0x010
    vecs[10] = mk(1'b1, 12'h010, 1'b0, 1'b0, 12'h123, 14'h3333, 14'h1111, 1'b0, 1'b0, 14'h0555, 12'h010, 14'h3333, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(1'b1, 12'h020, 1'b0, 1'b0, 12'h123, 14'h3333, 14'h1111, 1'b0, 1'b0, 14'h0555, 12'h010, 14'h3333, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(1'b1, 12'h020, 1'b0, 1'b0, 12'h123, 14'h3333, 14'h1111, 1'b1, 1'b0, 14'h1111, 12'h010, 14'h3333, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 12'h020, 1'b0, 1'b0, 12'h123, 14'h3333, 14'h1111, 1'b0, 1'b0, 14'h1111, 12'h010, 14'h3333, 1'b0, 1'b0, 1'b0);

    // reset state
    rst_n         = 1'b0;
    gif.f_req     = 1'b0;
    gif.f_addr    = 12'h000;
    gif.x_req     = 1'b0;
    gif.x_we      = 1'b0;
    gif.x_addr    = 12'h000;
    gif.x_wdata   = 14'h0000;
    gif.bus_rdata = 14'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_outputs", 64'(outs()), 64'h0);

    // table-driven vectors
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp_out));
    end

    // both requests held: X,X,X,F,X,X,X,F with f_ack every 12 cycles
    gif.f_req     = 1'b1;
    gif.f_addr    = 12'h040;
    gif.x_req     = 1'b1;
    gif.x_we      = 1'b0;
    gif.x_addr    = 12'h300;
    gif.x_wdata   = 14'h0000;
    gif.bus_rdata = 14'h0AAA;
    n_acks = 0;
    viol   = 0;
    last_f = -1;
    f_gap  = 0;
    got_f  = 8'h00;
    for (int c = 0; c < 80 && n_acks < 8; c++) begin
      @(posedge clk);
      #1;
      if (gif.f_ack && gif.x_ack) viol++;
      if (gif.bus_we && gif.bus_rd) viol++;
      if (gif.f_ack || gif.x_ack) begin
        got_f[n_acks] = gif.f_ack;
        if (gif.f_ack) begin
          if (last_f >= 0) f_gap = c - last_f;
          last_f = c;
        end
        n_acks++;
      end
    end
    gif.f_req = 1'b0;
    gif.x_req = 1'b0;
    check("starve_ack_count", 64'(n_acks), 64'd8);
    check("starve_order", 64'(got_f), 64'h88);
    check("starve_f_period", 64'(f_gap), 64'd12);
    check("ack_strobe_exclusive", 64'(viol), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset asserted in the first busy cycle of an execute write
    gif.x_req   = 1'b1;
    gif.x_we    = 1'b1;
    gif.x_addr  = 12'h200;
    gif.x_wdata = 14'h0F0F;
    @(posedge clk);
    #1;
    check("rst_pre_we_pause", 64'({gif.bus_we, gif.pause_read}), 64'h3);
    rst_n     = 1'b0;
    gif.x_req = 1'b0;
    #1;
    check("rst_async_outputs", 64'(outs()), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (gif.f_ack || gif.x_ack || gif.bus_we || gif.bus_rd || gif.pause_read)
        quiet_bad++;
    end
    check("post_reset_quiet", 64'(quiet_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gbus_arbiter.md
Name: gbus_arbiter

Overview:
- Shares the single general bus (address, write strobe, write data, read data) between two requesters: the fetch stage (ROM read path) and the execute stage (data load/store).
- Execute has priority. A starvation counter guarantees fetch progress.
- Drives pause_read to hold the fetch stage while execute owns the bus.
- Sits between the pipeline stages and the memory/bus interconnect in the CPU top level.

Parameters:
- DATA_W, 14, bus data width.
- ADDR_W, 12, bus address width.
- MEM_LAT, 2, number of cycles a granted transaction drives the bus (>=1).
- STARVE_MAX, 3, consecutive execute grants with fetch waiting before fetch is forced to win (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; level, held with f_addr until f_ack.
- f_addr  in  ADDR_W  fetch read address.
- f_ack  out  1  one-cycle pulse: fetch transaction done, rd_data valid.
- x_req  in  1  execute request; level, held with payload until x_ack.
- x_we  in  1  execute: 1 = write, 0 = read.
- x_addr  in  ADDR_W  execute address.
- x_wdata  in  DATA_W  execute write data.
- x_ack  out  1  one-cycle pulse: execute transaction done.
- rd_data  out  DATA_W  captured bus read data; valid in the ack cycle.
- bus_addr  out  ADDR_W  general bus address.
- bus_wdata  out  DATA_W  general bus write data.
- bus_we  out  1  bus write strobe.
- bus_rd  out  1  bus read strobe.
- bus_rdata  in  DATA_W  bus read data; valid in the last busy cycle.
- pause_read  out  1  holds the fetch stage while execute owns the bus.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All outputs 0: f_ack, x_ack, rd_data, bus_addr, bus_wdata, bus_we, bus_rd, pause_read.
  - Reset mid-transaction abandons it. No ack is issued. Requesters re-request after reset.
- All outputs are registered.
- States:
  - IDLE: bus strobes 0, bus_addr/bus_wdata hold their last values.
  - BUSY: lat_cnt counts MEM_LAT-1 down to 0.
- Arbitration, evaluated in IDLE on each rising edge:
  - x_req & !(f_req & starve_cnt==STARVE_MAX) -> grant X.
  - else f_req -> grant F.
  - else stay IDLE.
- starve_cnt update, at each grant only:
  - Grant X while f_req=1 -> starve_cnt+1, saturating at STARVE_MAX.
  - Grant F -> starve_cnt=0.
  - Grant X while f_req=0 -> starve_cnt=0.
- On grant (edge ending cycle T):
  - Latch the winner's address/we/wdata onto the bus regs.
  - bus_rd = !we (always 1 for F); bus_we = we (X only).
  - pause_read = (owner==X). state=BUSY, lat_cnt=MEM_LAT-1.
- Bus timing: strobes are asserted in cycles T+1 .. T+MEM_LAT. Address and data are stable throughout.
- At the edge ending cycle T+MEM_LAT:
  - rd_data <= bus_rdata, reads only; a write leaves rd_data unchanged.
  - The owner's ack is set to 1 for exactly cycle T+MEM_LAT+1.
  - Strobes go to 0, pause_read=0, state=IDLE.
- Ack cycle:
  - Arbitration runs normally in the ack cycle.
  - A req sampled high in the ack cycle is treated as a new request. A requester with no further work deasserts req in its ack cycle.
  - Back-to-back throughput is one transaction per MEM_LAT+1 cycles.
- Req changes during BUSY are ignored. Payload is latched at grant.
- Simultaneous f_req and x_req with starve_cnt<STARVE_MAX -> X wins.
- The arbiter never asserts f_ack and x_ack in the same cycle. bus_we and bus_rd are never both 1.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding (IDLE, BUSY).
  - Owner encoding (NONE, F, X).
  - Default widths: DATA_W=14, ADDR_W=12.
- One sub-module: gbus_starve_counter.
  - Inputs: clk, reset, grant_x, grant_f, f_req.
  - Output: at_max.
  - Contains the saturating counter described above.

Test Plan (MEM_LAT=2, STARVE_MAX=3):
- Reset release, f_req=1, f_addr=0x010 -> bus_rd=1, bus_addr=0x010 for 2 cycles; bus_rdata=0x1ABC in the 2nd cycle; f_ack=1 with rd_data=0x1ABC exactly 1 cycle later; pause_read stays 0.
- x_req write, x_addr=0x200, x_wdata=0x0F0F -> bus_we=1 for 2 cycles with that addr/data; pause_read=1 for the same 2 cycles; x_ack pulse; rd_data unchanged.
- f_req and x_req held continuously -> grant order X,X,X,F,X,X,X,F; f_ack every 12 cycles; starve_cnt back to 0 after each F grant.
- x_req read in the ack cycle of a prior X -> next bus_rd asserted 1 cycle after the ack (3-cycle period); no gap cycles beyond the IDLE cycle.
- Assert reset at the 1st busy cycle of an X write -> bus_we, pause_read and x_ack all drop to 0 immediately; no ack after reset release with both reqs low.
- f_addr changed from 0x010 to 0x020 mid-transaction -> bus_addr stays 0x010 until the ack.
